// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types, SPI mode encodings and helper functions for spi_slave_mw
package spi_pkg;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } frame_state_t;

    // Modes 0 and 3 sample on the rising SCK edge, modes 1 and 2 on the falling one.
    function automatic logic spi_sample_on_rise(input logic cpol, input logic cpha);
        logic r;
        case ({cpol, cpha})
            SPI_MODE0, SPI_MODE3: r = 1'b1;
            SPI_MODE1, SPI_MODE2: r = 1'b0;
            default:              r = 1'b1;
        endcase
        return r;
    endfunction

    // Folds the low `width` bits of data into the CRC, most significant bit first.
    function automatic logic [7:0] crc8_word(input logic [7:0] crc, input logic [31:0] data,
                                             input int width);
        logic [7:0] c;
        logic       fb;
        c = crc;
        for (int i = 31; i >= 0; i--) begin
            if (i < width) begin
                fb = c[7] ^ data[i];
                c  = {c[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - multi-flop synchroniser with one-cycle-delayed copy for edge detection
module spi_sync
    import spi_pkg::*;
#(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [DEPTH-1:0] sr;
    logic             prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sr   <= {DEPTH{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sr   <= {sr[DEPTH-2:0], d};
            prev <= sr[DEPTH-1];
        end
    end

    assign q    = sr[DEPTH-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/spi_slave_mw.sv
// rtl/spi_slave_mw.sv - multi-word SPI slave, all CPOL/CPHA modes, oversampled in the clk domain
// Optional per-frame CRC-8 over received words when SPI_SLAVE_MW_CRC_EN is defined.
module spi_slave_mw
    import spi_pkg::*;
#(
    parameter int WORD_W      = 8,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_active,
    output logic              frame_done,
    output logic              frame_err,
    output logic              tx_underrun
`ifdef SPI_SLAVE_MW_CRC_EN
    ,
    output logic [7:0]        crc8
`endif
);

    localparam bit          SAMPLE_RISE = spi_sample_on_rise(CPOL, CPHA);
    localparam int          CNT_W       = $clog2(WORD_W);
    localparam [CNT_W-1:0]  LAST_BIT    = CNT_W'(WORD_W - 1);

    logic sck_s, sck_rise, sck_fall;
    logic ss_s, ss_rise, ss_fall;
    logic mosi_s, mosi_unused_rise, mosi_unused_fall;

    spi_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(CPOL)) u_sck_sync (
        .clk(clk), .rst(rst), .d(sck), .q(sck_s), .rise(sck_rise), .fall(sck_fall)
    );
    spi_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk(clk), .rst(rst), .d(ss_n), .q(ss_s), .rise(ss_rise), .fall(ss_fall)
    );
    spi_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst(rst), .d(mosi), .q(mosi_s), .rise(mosi_unused_rise), .fall(mosi_unused_fall)
    );

    frame_state_t      state_q, state_d;
    logic              do_start, do_end, sck_en;
    logic              sample_edge, shift_edge, do_load;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] tx_sr, rx_sr, rx_next, tx_adv;
    logic              load_pending, skip_first;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // SCK edges only count inside a frame and never in the clk of an ss_n edge.
    always_comb begin
        state_d  = state_q;
        do_start = 1'b0;
        do_end   = 1'b0;
        sck_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ss_fall) begin
                    do_start = 1'b1;
                    state_d  = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (ss_rise) begin
                    do_end  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    sck_en = 1'b1;
                end
            end
        endcase
    end

    assign sample_edge = sck_en & (SAMPLE_RISE ? sck_rise : sck_fall);
    assign shift_edge  = sck_en & (SAMPLE_RISE ? sck_fall : sck_rise);
    assign do_load     = do_start | (shift_edge & load_pending);

    assign rx_next = MSB_FIRST ? {rx_sr[WORD_W-2:0], mosi_s} : {mosi_s, rx_sr[WORD_W-1:1]};
    assign tx_adv  = MSB_FIRST ? {tx_sr[WORD_W-2:0], 1'b0} : {1'b0, tx_sr[WORD_W-1:1]};

    assign frame_active = ~ss_s;
    assign miso         = frame_active & (MSB_FIRST ? tx_sr[WORD_W-1] : tx_sr[0]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_sr        <= '0;
            tx_ready     <= 1'b0;
            tx_underrun  <= 1'b0;
            load_pending <= 1'b0;
            skip_first   <= 1'b0;
        end else begin
            tx_ready    <= 1'b0;
            tx_underrun <= 1'b0;
            if (do_load) begin
                tx_sr        <= tx_valid ? tx_data : '0;
                tx_ready     <= tx_valid;
                tx_underrun  <= ~tx_valid;
                load_pending <= 1'b0;
                skip_first   <= do_start & CPHA;
            end else if (do_end) begin
                tx_sr        <= '0;
                load_pending <= 1'b0;
                skip_first   <= 1'b0;
            end else if (sample_edge && bit_cnt == LAST_BIT) begin
                load_pending <= 1'b1;
            end else if (shift_edge) begin
                // In CPHA=1 the first leading edge of a frame just launches the preloaded MSB/LSB.
                if (skip_first) skip_first <= 1'b0;
                else            tx_sr      <= tx_adv;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt    <= '0;
            rx_sr      <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (do_start) begin
                bit_cnt <= '0;
                rx_sr   <= '0;
            end else if (do_end) begin
                frame_done <= 1'b1;
                frame_err  <= (bit_cnt != '0);
                bit_cnt    <= '0;
                rx_sr      <= '0;
            end else if (sample_edge) begin
                rx_sr <= rx_next;
                if (bit_cnt == LAST_BIT) begin
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                    bit_cnt  <= '0;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef SPI_SLAVE_MW_CRC_EN
    logic [31:0] rx_ext;

    always_comb begin
        rx_ext                 = '0;
        rx_ext[WORD_W-1:0]     = rx_data;
    end

    always_ff @(posedge clk) begin
        if (!rst)          crc8 <= 8'h00;
        else if (do_start) crc8 <= 8'h00;
        else if (rx_valid) crc8 <= crc8_word(crc8, rx_ext, WORD_W);
    end
`endif

endmodule

// File: tb/tb_spi_slave_mw.sv
// tb/tb_spi_slave_mw.sv - directed bench for spi_slave_mw across modes, widths and bit orders
module tb_spi_slave_mw;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sck = 1'b0;
    logic        mosi = 1'b0;
    logic [4:0]  ss_v = 5'b11111;
    logic [15:0] tx16 = 16'h0000;
    logic        tv = 1'b0;

    logic [4:0]  miso_v, txr, rxv, fa, fd, fe, und;
    logic [7:0]  rxd0, rxd1, rxd2, rxd4;
    logic [15:0] rxd3;
    logic [15:0] rxd_v [5];
    logic [7:0]  crc0;

    int          sel = 0;
    int          n_checks = 0;
    int          n_errs = 0;
    int          n_rx, n_txr, n_und, n_fd;
    logic        last_fe;
    logic [15:0] rx_log [16];
    logic [15:0] txq [$];
    logic [31:0] mi0, mi1, mi2;

    always #5 clk = ~clk;

    spi_slave_mw #(.WORD_W(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst(rst), .sck(sck), .ss_n(ss_v[0]), .mosi(mosi), .miso(miso_v[0]),
        .tx_data(tx16[7:0]), .tx_valid(tv), .tx_ready(txr[0]), .rx_data(rxd0), .rx_valid(rxv[0]),
        .frame_active(fa[0]), .frame_done(fd[0]), .frame_err(fe[0]), .tx_underrun(und[0])
`ifdef SPI_SLAVE_MW_CRC_EN
        , .crc8(crc0)
`endif
    );
    spi_slave_mw #(.WORD_W(8), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b1)) u1 (
        .clk(clk), .rst(rst), .sck(sck), .ss_n(ss_v[1]), .mosi(mosi), .miso(miso_v[1]),
        .tx_data(tx16[7:0]), .tx_valid(tv), .tx_ready(txr[1]), .rx_data(rxd1), .rx_valid(rxv[1]),
        .frame_active(fa[1]), .frame_done(fd[1]), .frame_err(fe[1]), .tx_underrun(und[1])
    );
    spi_slave_mw #(.WORD_W(8), .CPOL(1'b1), .CPHA(1'b0), .MSB_FIRST(1'b1)) u2 (
        .clk(clk), .rst(rst), .sck(sck), .ss_n(ss_v[2]), .mosi(mosi), .miso(miso_v[2]),
        .tx_data(tx16[7:0]), .tx_valid(tv), .tx_ready(txr[2]), .rx_data(rxd2), .rx_valid(rxv[2]),
        .frame_active(fa[2]), .frame_done(fd[2]), .frame_err(fe[2]), .tx_underrun(und[2])
    );
    spi_slave_mw #(.WORD_W(16), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1)) u3 (
        .clk(clk), .rst(rst), .sck(sck), .ss_n(ss_v[3]), .mosi(mosi), .miso(miso_v[3]),
        .tx_data(tx16), .tx_valid(tv), .tx_ready(txr[3]), .rx_data(rxd3), .rx_valid(rxv[3]),
        .frame_active(fa[3]), .frame_done(fd[3]), .frame_err(fe[3]), .tx_underrun(und[3])
    );
    spi_slave_mw #(.WORD_W(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b0)) u4 (
        .clk(clk), .rst(rst), .sck(sck), .ss_n(ss_v[4]), .mosi(mosi), .miso(miso_v[4]),
        .tx_data(tx16[7:0]), .tx_valid(tv), .tx_ready(txr[4]), .rx_data(rxd4), .rx_valid(rxv[4]),
        .frame_active(fa[4]), .frame_done(fd[4]), .frame_err(fe[4]), .tx_underrun(und[4])
    );

    assign rxd_v[0] = {8'h00, rxd0};
    assign rxd_v[1] = {8'h00, rxd1};
    assign rxd_v[2] = {8'h00, rxd2};
    assign rxd_v[3] = rxd3;
    assign rxd_v[4] = {8'h00, rxd4};

    always @(negedge clk) begin
        if (rxv[sel]) begin
            if (n_rx < 16) rx_log[n_rx] = rxd_v[sel];
            n_rx++;
        end
        if (txr[sel]) begin
            n_txr++;
            if (txq.size() > 0) tx16 = txq.pop_front();
        end
        if (und[sel]) n_und++;
        if (fd[sel]) begin
            n_fd++;
            last_fe = fe[sel];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        n_rx = 0; n_txr = 0; n_und = 0; n_fd = 0; last_fe = 1'b0;
    endtask

    task automatic frame_begin(input int d, input logic cpol);
        sel = d;
        sck = cpol;
        repeat (6) @(negedge clk);
        clear_counts();
        ss_v[d] = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic frame_end(input int d);
        repeat (HALF) @(negedge clk);
        ss_v[d] = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_word(input logic cpol, input logic cpha, input logic msb, input int w,
                            input int nbits, input logic [31:0] mo, output logic [31:0] mi);
        int b;
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            b = msb ? (w - 1 - i) : i;
            if (!cpha) begin
                mosi = mo[b];
                repeat (HALF) @(negedge clk);
                sck   = ~cpol;
                mi[b] = miso_v[sel];
                repeat (HALF) @(negedge clk);
                sck = cpol;
            end else begin
                sck  = ~cpol;
                mosi = mo[b];
                repeat (HALF) @(negedge clk);
                sck   = cpol;
                mi[b] = miso_v[sel];
                repeat (HALF) @(negedge clk);
            end
        end
    endtask

    initial begin
        clear_counts();
        repeat (4) @(negedge clk);
        chk("rst_miso", {27'd0, miso_v}, 32'd0);
        chk("rst_active", {27'd0, fa}, 32'd0);
        chk("rst_pulses", {7'd0, rxv, txr, und, fd, fe}, 32'd0);
        chk("rst_rxdata", {rxd3, rxd0, rxd4}, 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Mode 0, one byte each way
        tv = 1'b1; tx16 = 16'h00A5;
        frame_begin(0, 1'b0);
        chk("m0_txr_start", n_txr, 1);
        chk("m0_active", fa[0], 1);
        spi_word(1'b0, 1'b0, 1'b1, 8, 8, 32'h3C, mi0);
        frame_end(0);
        chk("m0_miso", mi0, 32'hA5);
        chk("m0_nrx", n_rx, 1);
        chk("m0_rxd", rx_log[0], 16'h3C);
        chk("m0_ntxr", n_txr, 2);
        chk("m0_fdone", n_fd, 1);
        chk("m0_ferr", last_fe, 0);
        chk("m0_inactive", fa[0], 0);

        // Mode 3, three 16-bit words
        tx16 = 16'hBEEF; txq.push_back(16'hCAFE); txq.push_back(16'h5555);
        frame_begin(3, 1'b1);
        spi_word(1'b1, 1'b1, 1'b1, 16, 16, 32'h1234, mi0);
        spi_word(1'b1, 1'b1, 1'b1, 16, 16, 32'hABCD, mi1);
        spi_word(1'b1, 1'b1, 1'b1, 16, 16, 32'h0001, mi2);
        frame_end(3);
        chk("m3_miso0", mi0, 32'hBEEF);
        chk("m3_miso1", mi1, 32'hCAFE);
        chk("m3_miso2", mi2, 32'h5555);
        chk("m3_nrx", n_rx, 3);
        chk("m3_rx0", rx_log[0], 16'h1234);
        chk("m3_rx1", rx_log[1], 16'hABCD);
        chk("m3_rx2", rx_log[2], 16'h0001);
        chk("m3_ntxr", n_txr, 3);
        chk("m3_ferr", {n_fd[7:0], 7'd0, last_fe}, {8'd1, 8'd0});

        // Mode 1, no TX data offered
        tv = 1'b0; tx16 = 16'hFFFF;
        frame_begin(1, 1'b0);
        spi_word(1'b0, 1'b1, 1'b1, 8, 8, 32'hC3, mi0);
        spi_word(1'b0, 1'b1, 1'b1, 8, 8, 32'h7E, mi1);
        frame_end(1);
        chk("m1_miso0", mi0, 32'h0);
        chk("m1_miso1", mi1, 32'h0);
        chk("m1_nund", n_und, 2);
        chk("m1_ntxr", n_txr, 0);
        chk("m1_rx", {rx_log[0], rx_log[1]}, {16'h00C3, 16'h007E});

        // Mode 2, full word then aborted word
        tv = 1'b1; tx16 = 16'h0096;
        frame_begin(2, 1'b1);
        spi_word(1'b1, 1'b0, 1'b1, 8, 8, 32'h5A, mi0);
        frame_end(2);
        chk("m2_miso", mi0, 32'h96);
        chk("m2_rx", rx_log[0], 16'h5A);
        chk("m2_ferr_ok", last_fe, 0);
        frame_begin(2, 1'b1);
        spi_word(1'b1, 1'b0, 1'b1, 8, 5, 32'hFF, mi0);
        frame_end(2);
        chk("m2_abort_nrx", n_rx, 0);
        chk("m2_abort_fd", n_fd, 1);
        chk("m2_abort_ferr", last_fe, 1);
        chk("m2_abort_rxd", rxd2, 8'h5A);

        // LSB-first, then reset in the middle of a word
        tx16 = 16'h0081;
        frame_begin(4, 1'b0);
        spi_word(1'b0, 1'b0, 1'b0, 8, 8, 32'h01, mi0);
        frame_end(4);
        chk("lsb_rx", rx_log[0], 16'h01);
        chk("lsb_miso", mi0, 32'h81);
        frame_begin(4, 1'b0);
        spi_word(1'b0, 1'b0, 1'b0, 8, 3, 32'hFF, mi0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rxd", rxd4, 8'h00);
        chk("midrst_active", fa[4], 0);
        chk("midrst_miso", miso_v[4], 0);
        chk("midrst_pulses", {27'd0, rxv[4], txr[4], und[4], fd[4], fe[4]}, 32'd0);
        clear_counts();
        rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst_restart", {n_txr[7:0], 7'd0, fa[4]}, {8'd1, 8'd1});
        spi_word(1'b0, 1'b0, 1'b0, 8, 8, 32'h5C, mi0);
        frame_end(4);
        chk("midrst_rx", {n_rx[7:0], rx_log[0][7:0]}, {8'd1, 8'h5C});
        chk("midrst_ferr", last_fe, 0);

`ifdef SPI_SLAVE_MW_CRC_EN
        frame_begin(0, 1'b0);
        chk("crc_init", crc0, 8'h00);
        spi_word(1'b0, 1'b0, 1'b1, 8, 8, 32'h01, mi0);
        frame_end(0);
        chk("crc_01", crc0, 8'h07);
        frame_begin(0, 1'b0);
        chk("crc_restart", crc0, 8'h00);
        for (int k = 0; k < 9; k++) spi_word(1'b0, 1'b0, 1'b1, 8, 8, 32'h31 + k, mi0);
        frame_end(0);
        chk("crc_check", crc0, 8'hF4);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/spi_slave_mw.md
Name: spi_slave_mw

Overview:
Parametrised SPI slave, successor to the single-byte SPI slave. Supports all four CPOL/CPHA modes, configurable word width and bit order, and multi-word frames with a streaming TX/RX handshake. Sits between the external SPI pins and the register/command layer. Runs entirely in the system clock domain, with synchronised inputs and oversampled SCK.

Parameters:
- WORD_W, 8, bits per word (4..32).
- CPOL, 0, SCK idle level.
- CPHA, 0, 0 = sample on leading edge / 1 = sample on trailing edge.
- MSB_FIRST, 1, 1 = MSB shifted first on MOSI and MISO.
- SYNC_STAGES, 2, synchroniser depth for sck/ss_n/mosi (>=2).

Ports:
- clk  in  1  system clock; must be >= 4x SCK frequency
- rst  in  1  synchronous active-low reset
- sck  in  1  SPI clock, asynchronous
- ss_n  in  1  chip select, active low, asynchronous
- mosi  in  1  master data in
- miso  out  1  slave data out; 0 when ss_n deasserted (no tristate)
- tx_data  in  WORD_W  next word to transmit
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  1-clk pulse: tx_data consumed
- rx_data  out  WORD_W  last received word, held until next word
- rx_valid  out  1  1-clk pulse: rx_data updated
- frame_active  out  1  synchronised ss_n asserted
- frame_done  out  1  1-clk pulse on synchronised ss_n rising edge
- frame_err  out  1  with frame_done: frame ended mid-word (bit count != 0)
- tx_underrun  out  1  1-clk pulse: word load with tx_valid low, zeros sent

Behaviour:
- Reset (rst=0 at a clk edge) clears all state:
  - miso/tx_ready/rx_valid/frame_done/frame_err/tx_underrun = 0; rx_data = 0; frame_active = 0.
  - ss_n synchroniser resets to 1; sck synchroniser resets to CPOL; mosi synchroniser resets to 0.
- Synchronisation and edge detection:
  - sck, ss_n and mosi each pass through SYNC_STAGES flops; edges are detected against a one-cycle-delayed copy.
  - Pin-to-detect latency is SYNC_STAGES+1 clk.
  - Leading edge = rising if CPOL=0, else falling. Sample edge = leading if CPHA=0, else trailing. Shift edge = the other one.
- Frame start (ss_n falling detected):
  - Bit counter cleared; TX shift register loaded from tx_data.
  - tx_ready pulses if tx_valid=1; otherwise the register loads zeros and tx_underrun pulses.
  - For CPHA=0, miso shows the first bit from the next clk.
- Sample edge: the mosi synchroniser output shifts into the RX register (at the MSB/LSB end per MSB_FIRST); bit counter increments.
- Shift edge: the TX register advances one bit.
  - CPHA=1: the first shift edge of each word only launches; it does not advance.
  - CPHA=0: the shift edge after the last sample of a word loads the next word instead of advancing.
- Word complete (bit counter reaches WORD_W on a sample edge):
  - rx_data updated and rx_valid pulses in the same clk; counter wraps to 0.
  - Next TX word is loaded under the same tx_valid/underrun rule (CPHA=0 at the next shift edge; CPHA=1 at the next first-launch edge).
- Frame end (ss_n rising detected): frame_done pulses; frame_err = (bit counter != 0); partial RX bits are discarded, no rx_valid.
- Simultaneous events: an SCK edge detected in the same clk as an ss_n edge is ignored. SCK edges while ss_n is deasserted are ignored.
- ss_n held low across reset release: treated as a new frame start SYNC_STAGES+1 clk after release.
- No RX backpressure: the consumer must take rx_data within WORD_W SCK periods.

Optional Feature:
- Macro SPI_SLAVE_MW_CRC_EN.
- When defined: adds output crc8 [7:0], a CRC-8 (poly 0x07, init 0x00) computed over every completed RX word, MSB-first per word.
  - Resets to 0x00 at frame start.
  - Updates in the clk after each rx_valid.
  - Held valid from frame_done until the next frame start.
- When undefined: no crc8 port and no CRC logic.

Decomposition:
- Package spi_pkg holds:
  - mode constants: SPI_MODE0..3 as {CPOL,CPHA}, 2 bits;
  - CRC8_POLY = 8'h07;
  - a function that computes the sample-edge polarity from CPOL/CPHA.
- One sub-module, spi_sync: parametrised-depth synchroniser plus prev flop, outputting sync level, rise and fall. Instantiated for sck and ss_n; mosi uses the level output only.

Test Plan:
- Mode 0, WORD_W=8, MSB_FIRST=1, tx_valid=1 tx_data=8'hA5, master sends 8'h3C: miso carries A5 MSB-first; rx_valid once with rx_data=8'h3C; tx_ready at frame start; frame_done with frame_err=0.
- Mode 3, WORD_W=16, 3-word frame 16'h1234/16'hABCD/16'h0001, tx words 16'hBEEF/16'hCAFE/16'h5555: exactly three rx_valid pulses with matching data; master captures all tx words; three tx_ready pulses.
- Mode 1, tx_valid=0 throughout: tx_underrun at every word load; miso=0; RX still correct.
- Mode 2, ss_n deasserted after 5 of 8 SCKs: frame_done with frame_err=1, no rx_valid, rx_data unchanged.
- MSB_FIRST=0, master sends 8'h01 LSB-first: rx_data=8'h01. Assert rst=0 mid-word: all outputs return to reset values on the next clk and the partial word is lost.
- With SPI_SLAVE_MW_CRC_EN, frame of single byte 8'h01: crc8=8'h07 after frame_done; bytes 8'h31..8'h39 ("123456789") give crc8=8'hF4.
